// File: rtl/burst_line_assembler_if.sv
// Cache-refill / AXI-read bundle for burst_line_assembler.
// master: the assembler; slave: cache + interconnect side.
interface burst_line_assembler_if #(
  parameter int BEAT_W = 32,
  parameter int BEATS  = 8,
  parameter int ADDR_W = 32
);
  localparam int LINE_W = BEAT_W * BEATS;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arready;
  logic              rvalid;
  logic [BEAT_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rready;
  logic              crit_valid;
  logic [BEAT_W-1:0] crit_data;
  logic              line_valid;
  logic [LINE_W-1:0] line_data;
  logic [ADDR_W-1:0] line_addr;
  logic              line_err;
  logic              line_ready;

  modport master (
    input  req_valid, req_addr, arready,
    input  rvalid, rdata, rresp, rlast,
    input  line_ready,
    output req_ready, arvalid, araddr,
    output arlen, arsize, arburst, rready,
    output crit_valid, crit_data,
    output line_valid, line_data,
    output line_addr, line_err
  );

  modport slave (
    output req_valid, req_addr, arready,
    output rvalid, rdata, rresp, rlast,
    output line_ready,
    input  req_ready, arvalid, araddr,
    input  arlen, arsize, arburst, rready,
    input  crit_valid, crit_data,
    input  line_valid, line_data,
    input  line_addr, line_err
  );
endinterface

// File: rtl/burst_line_assembler.sv
// Cache-line refill: one AXI read burst packed into a line,
// critical word reported early, protocol errors flagged.
module burst_line_assembler #(
  parameter int BEAT_W = 32,
  parameter int BEATS  = 8,
  parameter int ADDR_W = 32,
  parameter int WRAP   = 0
) (
  input logic clk,
  input logic resetn,
  burst_line_assembler_if.master bus
);
  localparam int OFF    = $clog2(BEAT_W / 8);
  localparam int IDX    = $clog2(BEATS);
  localparam int LINE_W = BEAT_W * BEATS;
  localparam logic [IDX-1:0] LAST = IDX'(BEATS - 1);
  localparam logic [ADDR_W-1:0] BEAT_MASK =
    ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << (OFF + IDX)) - ADDR_W'(1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_DATA,
    S_OUT
  } state_t;

  state_t            r_state;
  logic              r_req_ready;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_crit_valid;
  logic              r_line_valid;
  logic              r_err;
  logic [ADDR_W-1:0] r_araddr;
  logic [IDX-1:0]    r_idx;
  logic [IDX-1:0]    r_start;
  logic [IDX-1:0]    r_cnt;
  logic [BEAT_W-1:0] r_crit_data;
  logic [LINE_W-1:0] r_line;

  logic           w_req;
  logic           w_beat;
  logic           w_final;
  logic           w_end;
  logic           w_bad;
  logic [IDX-1:0] w_slot;
  logic [IDX-1:0] w_req_idx;

  assign w_req     = bus.req_valid && r_req_ready;
  assign w_beat    = bus.rvalid && r_rready;
  assign w_final   = (r_cnt == LAST);
  assign w_end     = w_beat && (w_final || bus.rlast);
  assign w_bad     = (bus.rresp != 2'b00) ||
                     (bus.rlast != w_final);
  // slot index wraps naturally in IDX bits
  assign w_slot    = r_start + r_cnt;
  assign w_req_idx = bus.req_addr[OFF+IDX-1:OFF];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_crit_valid <= 1'b0;
      r_line_valid <= 1'b0;
      r_err        <= 1'b0;
      r_araddr     <= '0;
      r_idx        <= '0;
      r_start      <= '0;
      r_cnt        <= '0;
      r_crit_data  <= '0;
      r_line       <= '0;
    end else begin
      r_crit_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_req) begin
            r_req_ready <= 1'b0;
            r_arvalid   <= 1'b1;
            r_idx       <= w_req_idx;
            r_start     <= (WRAP != 0) ? w_req_idx : '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_araddr    <= bus.req_addr &
              ((WRAP != 0) ? BEAT_MASK : LINE_MASK);
            r_state     <= S_AR;
          end
        end
        S_AR: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_line[w_slot*BEAT_W +: BEAT_W] <= bus.rdata;
            r_cnt <= r_cnt + 1'b1;
            if (w_slot == r_idx) begin
              r_crit_valid <= 1'b1;
              r_crit_data  <= bus.rdata;
            end
            if (w_bad) r_err <= 1'b1;
            // early rlast also closes the burst
            if (w_end) begin
              r_rready     <= 1'b0;
              r_line_valid <= 1'b1;
              r_state      <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (bus.line_ready) begin
            r_line_valid <= 1'b0;
            r_err        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.arvalid    = r_arvalid;
  assign bus.araddr     = r_araddr;
  assign bus.arlen      = 8'(BEATS - 1);
  assign bus.arsize     = 3'(OFF);
  assign bus.arburst    = (WRAP != 0) ? 2'b10 : 2'b01;
  assign bus.rready     = r_rready;
  assign bus.crit_valid = r_crit_valid;
  assign bus.crit_data  = r_crit_data;
  assign bus.line_valid = r_line_valid;
  assign bus.line_data  = r_line;
  assign bus.line_addr  = r_araddr & LINE_MASK;
  assign bus.line_err   = r_err;
endmodule

// File: tb/tb_burst_line_assembler.sv
// Directed bench for burst_line_assembler: INCR and WRAP
// ordering, stalls, back-pressure, errors and reset.
module tb_burst_line_assembler;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [255:0] exp0;

  always #5 clk = ~clk;

  burst_line_assembler_if #(.BEAT_W(32), .BEATS(8), .ADDR_W(32)) b0 ();
  burst_line_assembler_if #(.BEAT_W(32), .BEATS(8), .ADDR_W(32)) b1 ();
  burst_line_assembler_if #(.BEAT_W(64), .BEATS(4), .ADDR_W(32)) b2 ();

  burst_line_assembler #(
    .BEAT_W(32), .BEATS(8), .ADDR_W(32), .WRAP(0)
  ) u0 (.clk(clk), .resetn(resetn), .bus(b0.master));

  burst_line_assembler #(
    .BEAT_W(32), .BEATS(8), .ADDR_W(32), .WRAP(1)
  ) u1 (.clk(clk), .resetn(resetn), .bus(b1.master));

  burst_line_assembler #(
    .BEAT_W(64), .BEATS(4), .ADDR_W(32), .WRAP(1)
  ) u2 (.clk(clk), .resetn(resetn), .bus(b2.master));

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // one refill on u0; cycle 0 is the request cycle
  task automatic run0(
    input  logic [31:0] addr,
    input  int          ar_delay,
    input  bit          stall,
    input  int          last_at,
    input  int          bad_beat,
    output int          lv_cyc,
    output int          crit_cyc,
    output logic [31:0] crit_d,
    output logic [31:0] ar_addr,
    output bit          ar_ok,
    output bit          busy_ok
  );
    int c;
    int beat;
    bit seen;
    lv_cyc = -1; crit_cyc = -1; crit_d = '0;
    ar_addr = '0; ar_ok = 1'b1; busy_ok = 1'b1;
    beat = 0; seen = 1'b0;
    @(negedge clk);
    b0.req_valid = 1'b1;
    b0.req_addr  = addr;
    c = 0;
    while (c < 80 && lv_cyc < 0) begin
      @(negedge clk);
      c++;
      if (b0.req_ready) busy_ok = 1'b0;
      if (b0.arvalid) begin
        if (!seen) ar_addr = b0.araddr;
        else if (b0.araddr !== ar_addr) ar_ok = 1'b0;
        seen = 1'b1;
      end
      if (b0.crit_valid) begin
        crit_cyc = c;
        crit_d = b0.crit_data;
      end
      if (b0.line_valid) lv_cyc = c;
      b0.arready = (c >= 1 + ar_delay);
      if (beat <= last_at) begin
        b0.rvalid = stall ? (c % 2 == 0) : 1'b1;
        b0.rdata  = 32'(beat);
        b0.rlast  = (beat == last_at);
        b0.rresp  = (beat == bad_beat) ? 2'b10 : 2'b00;
      end else begin
        b0.rvalid = 1'b0;
        b0.rlast  = 1'b0;
        b0.rresp  = 2'b00;
      end
      if (b0.rready && b0.rvalid) beat++;
    end
    b0.req_valid = 1'b0;
    b0.arready = 1'b0;
    b0.rvalid = 1'b0;
    b0.rlast = 1'b0;
    b0.rresp = 2'b00;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({b0.req_ready, b0.arvalid, b0.rready, b0.crit_valid,
         b0.line_valid, b0.line_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=000000",
        {b0.req_ready, b0.arvalid, b0.rready, b0.crit_valid,
         b0.line_valid, b0.line_err});
    end
    checks++;
    if (b0.line_data !== '0 || b0.araddr !== '0) begin
      errors++;
      $display("FAIL reset_data line=%h araddr=%h exp=0",
        b0.line_data, b0.araddr);
    end
    checks++;
    if (b0.arlen !== 8'd7 || b0.arsize !== 3'd2 || b0.arburst !== 2'b01) begin
      errors++;
      $display("FAIL reset_const0 got=%h/%h/%h exp=07/2/1",
        b0.arlen, b0.arsize, b0.arburst);
    end
    checks++;
    if (b1.arburst !== 2'b10) begin
      errors++;
      $display("FAIL reset_const1 arburst got=%h exp=2", b1.arburst);
    end
    checks++;
    if (b2.arlen !== 8'd3 || b2.arsize !== 3'd3 || b2.arburst !== 2'b10) begin
      errors++;
      $display("FAIL reset_const2 got=%h/%h/%h exp=03/3/2",
        b2.arlen, b2.arsize, b2.arburst);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (b0.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle req_ready got=%b exp=1", b0.req_ready);
    end
  endtask

  task automatic accept0();
    b0.line_ready = 1'b1;
    @(negedge clk);
    b0.line_ready = 1'b0;
    checks++;
    if (b0.line_valid !== 1'b0 || b0.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept lv=%b rr=%b exp lv=0 rr=1",
        b0.line_valid, b0.req_ready);
    end
  endtask

  task automatic test_incr();
    int lv, cc;
    logic [31:0] cd, aa;
    bit ok, bz;
    run0(32'h1000_0014, 0, 1'b0, 7, -1, lv, cc, cd, aa, ok, bz);
    checks++;
    if (aa !== 32'h1000_0000) begin
      errors++;
      $display("FAIL incr_araddr got=%h exp=10000000", aa);
    end
    checks++;
    if (lv !== 10) begin
      errors++;
      $display("FAIL incr_latency got=%0d exp=10", lv);
    end
    checks++;
    if (cc !== 8 || cd !== 32'd5) begin
      errors++;
      $display("FAIL incr_crit cyc=%0d data=%h exp cyc=8 data=5", cc, cd);
    end
    checks++;
    if (b0.line_data !== exp0) begin
      errors++;
      $display("FAIL incr_line got=%h exp=%h", b0.line_data, exp0);
    end
    checks++;
    if (b0.line_addr !== 32'h1000_0000 || b0.line_err !== 1'b0) begin
      errors++;
      $display("FAIL incr_addr_err addr=%h err=%b exp 10000000/0",
        b0.line_addr, b0.line_err);
    end
    checks++;
    if (bz !== 1'b1) begin
      errors++;
      $display("FAIL incr_busy req_ready got=1 exp=0 while busy");
    end
    accept0();
  endtask

  task automatic test_stall();
    int lv, cc;
    logic [31:0] cd, aa;
    bit ok, bz;
    run0(32'h1000_0014, 3, 1'b1, 7, -1, lv, cc, cd, aa, ok, bz);
    checks++;
    if (ok !== 1'b1 || aa !== 32'h1000_0000) begin
      errors++;
      $display("FAIL stall_araddr stable=%b addr=%h exp 1/10000000", ok, aa);
    end
    checks++;
    if (lv !== 21) begin
      errors++;
      $display("FAIL stall_latency got=%0d exp=21", lv);
    end
    checks++;
    if (b0.line_data !== exp0 || b0.line_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_line got=%h err=%b exp=%h err=0",
        b0.line_data, b0.line_err, exp0);
    end
    checks++;
    if (cd !== 32'd5) begin
      errors++;
      $display("FAIL stall_crit got=%h exp=5", cd);
    end
    accept0();
  endtask

  task automatic test_backpressure();
    int lv, cc;
    logic [31:0] cd, aa;
    bit ok, bz;
    run0(32'h1000_0014, 0, 1'b0, 7, -1, lv, cc, cd, aa, ok, bz);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (b0.line_valid !== 1'b1 || b0.line_data !== exp0 ||
          b0.req_ready !== 1'b0 || b0.rready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d lv=%b rr=%b rdy=%b line=%h", i,
          b0.line_valid, b0.req_ready, b0.rready, b0.line_data);
      end
    end
    accept0();
  endtask

  task automatic test_errors();
    int lv, cc;
    logic [31:0] cd, aa;
    bit ok, bz;
    run0(32'h1000_0014, 0, 1'b0, 4, -1, lv, cc, cd, aa, ok, bz);
    checks++;
    if (lv !== 7 || b0.line_err !== 1'b1) begin
      errors++;
      $display("FAIL early_rlast lv=%0d err=%b exp 7/1", lv, b0.line_err);
    end
    checks++;
    if (b0.line_data !== exp0) begin
      errors++;
      $display("FAIL early_stale got=%h exp=%h", b0.line_data, exp0);
    end
    accept0();
    checks++;
    if (b0.line_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got=%b exp=0", b0.line_err);
    end
    run0(32'h1000_0014, 0, 1'b0, 7, 3, lv, cc, cd, aa, ok, bz);
    checks++;
    if (lv !== 10 || b0.line_err !== 1'b1) begin
      errors++;
      $display("FAIL rresp_err lv=%0d err=%b exp 10/1", lv, b0.line_err);
    end
    accept0();
    run0(32'h1000_0014, 0, 1'b0, 7, -1, lv, cc, cd, aa, ok, bz);
    checks++;
    if (lv !== 10 || b0.line_err !== 1'b0) begin
      errors++;
      $display("FAIL clean_after lv=%0d err=%b exp 10/0", lv, b0.line_err);
    end
    accept0();
  endtask

  task automatic test_back_to_back();
    int lv, cc;
    logic [31:0] cd, aa;
    bit ok, bz;
    b0.line_ready = 1'b1;
    run0(32'h1000_0014, 0, 1'b0, 7, -1, lv, cc, cd, aa, ok, bz);
    @(negedge clk);
    checks++;
    if (lv !== 10 || b0.line_valid !== 1'b0 || b0.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first lv=%0d valid=%b rr=%b exp 10/0/1",
        lv, b0.line_valid, b0.req_ready);
    end
    run0(32'h1000_0034, 0, 1'b0, 7, -1, lv, cc, cd, aa, ok, bz);
    checks++;
    if (lv !== 10 || aa !== 32'h1000_0020 || b0.line_addr !== 32'h1000_0020) begin
      errors++;
      $display("FAIL b2b_second lv=%0d ar=%h la=%h exp 10/10000020",
        lv, aa, b0.line_addr);
    end
    @(negedge clk);
    b0.line_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int c, beat, lv, cc;
    logic [31:0] cd, aa;
    logic [1:0] ab;
    logic [255:0] e;
    for (int s = 0; s < 8; s++) e[s*32 +: 32] = 32'hA0 + 32'((s + 1) % 8);
    lv = -1; cc = -1; cd = '0; aa = '0; ab = '0; beat = 0;
    @(negedge clk);
    b1.req_valid = 1'b1;
    b1.req_addr = 32'h1000_001C;
    c = 0;
    while (c < 40 && lv < 0) begin
      @(negedge clk);
      c++;
      b1.req_valid = 1'b0;
      if (b1.arvalid) begin aa = b1.araddr; ab = b1.arburst; end
      if (b1.crit_valid) begin cc = c; cd = b1.crit_data; end
      if (b1.line_valid) lv = c;
      b1.arready = 1'b1;
      b1.rvalid = (beat < 8);
      b1.rdata = 32'hA0 + 32'(beat);
      b1.rlast = (beat == 7);
      if (b1.rready && b1.rvalid) beat++;
    end
    b1.arready = 1'b0; b1.rvalid = 1'b0; b1.rlast = 1'b0;
    checks++;
    if (aa !== 32'h1000_001C || ab !== 2'b10) begin
      errors++;
      $display("FAIL wrap_ar addr=%h burst=%h exp 1000001c/2", aa, ab);
    end
    checks++;
    if (cc !== 3 || cd !== 32'hA0) begin
      errors++;
      $display("FAIL wrap_crit cyc=%0d data=%h exp 3/a0", cc, cd);
    end
    checks++;
    if (lv !== 10 || b1.line_data !== e || b1.line_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_line lv=%0d err=%b got=%h exp=%h",
        lv, b1.line_err, b1.line_data, e);
    end
    checks++;
    if (b1.line_addr !== 32'h1000_0000) begin
      errors++;
      $display("FAIL wrap_line_addr got=%h exp=10000000", b1.line_addr);
    end
    b1.line_ready = 1'b1;
    @(negedge clk);
    b1.line_ready = 1'b0;
  endtask

  task automatic test_beats4();
    int c, beat, lv, cc;
    logic [63:0] cd;
    logic [31:0] aa;
    logic [255:0] e;
    for (int s = 0; s < 4; s++)
      e[s*64 +: 64] = 64'hDEAD_0000_0000_0000 | 64'((s + 1) % 4);
    lv = -1; cc = -1; cd = '0; aa = '0; beat = 0;
    @(negedge clk);
    b2.req_valid = 1'b1;
    b2.req_addr = 32'h2000_0018;
    c = 0;
    while (c < 40 && lv < 0) begin
      @(negedge clk);
      c++;
      b2.req_valid = 1'b0;
      if (b2.arvalid) aa = b2.araddr;
      if (b2.crit_valid) begin cc = c; cd = b2.crit_data; end
      if (b2.line_valid) lv = c;
      b2.arready = 1'b1;
      b2.rvalid = (beat < 4);
      b2.rdata = 64'hDEAD_0000_0000_0000 | 64'(beat);
      b2.rlast = (beat == 3);
      if (b2.rready && b2.rvalid) beat++;
    end
    b2.arready = 1'b0; b2.rvalid = 1'b0; b2.rlast = 1'b0;
    checks++;
    if (aa !== 32'h2000_0018) begin
      errors++;
      $display("FAIL b4_araddr got=%h exp=20000018", aa);
    end
    checks++;
    if (cc !== 3 || cd !== 64'hDEAD_0000_0000_0000) begin
      errors++;
      $display("FAIL b4_crit cyc=%0d data=%h exp 3/dead000000000000", cc, cd);
    end
    checks++;
    if (lv !== 6 || b2.line_data !== e || b2.line_addr !== 32'h2000_0000) begin
      errors++;
      $display("FAIL b4_line lv=%0d la=%h got=%h exp=%h",
        lv, b2.line_addr, b2.line_data, e);
    end
    b2.line_ready = 1'b1;
    @(negedge clk);
    b2.line_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit lv_seen;
    @(negedge clk);
    b0.req_valid = 1'b1;
    b0.req_addr = 32'h1000_0014;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      b0.req_valid = 1'b0;
      b0.arready = 1'b1;
      b0.rvalid = 1'b1;
      b0.rdata = 32'h5A5A_0000 + 32'(c);
    end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({b0.req_ready, b0.arvalid, b0.rready, b0.crit_valid,
         b0.line_valid, b0.line_err} !== 6'b0 ||
        b0.line_data !== '0 || b0.line_addr !== '0) begin
      errors++;
      $display("FAIL midreset_outs ctrl=%b line=%h la=%h exp 0",
        {b0.req_ready, b0.arvalid, b0.rready, b0.crit_valid,
         b0.line_valid, b0.line_err}, b0.line_data, b0.line_addr);
    end
    resetn = 1'b1;
    lv_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b0.line_valid) lv_seen = 1'b1;
    end
    b0.rvalid = 1'b0;
    b0.arready = 1'b0;
    checks++;
    if (lv_seen !== 1'b0 || b0.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_after lv_seen=%b rr=%b exp 0/1",
        lv_seen, b0.req_ready);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) exp0[k*32 +: 32] = 32'(k);
    b0.req_valid = 0; b0.req_addr = '0; b0.arready = 0; b0.rvalid = 0;
    b0.rdata = '0; b0.rresp = '0; b0.rlast = 0; b0.line_ready = 0;
    b1.req_valid = 0; b1.req_addr = '0; b1.arready = 0; b1.rvalid = 0;
    b1.rdata = '0; b1.rresp = '0; b1.rlast = 0; b1.line_ready = 0;
    b2.req_valid = 0; b2.req_addr = '0; b2.arready = 0; b2.rvalid = 0;
    b2.rdata = '0; b2.rresp = '0; b2.rlast = 0; b2.line_ready = 0;
    test_reset();
    test_incr();
    test_stall();
    test_backpressure();
    test_errors();
    test_back_to_back();
    test_wrap();
    test_beats4();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
